// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single backend memory port.
// DM wins ties, bounded by a starvation streak that eventually forces IF.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        IFReq,
   input  logic [31:0] IFAddr,
   output logic [31:0] IFData,
   output logic        IFValid,
   input  logic        DMReq,
   input  logic        DMWrite,
   input  logic [31:0] DMAddr,
   input  logic [31:0] DMWData,
   output logic [31:0] DMRData,
   output logic        DMValid,
   output logic        MemReq,
   output logic        MemWrite,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   input  logic        MemAck,
   output logic        IFStall,
   output logic        DMStall,
   output logic        Busy
);

   localparam int SW =
      (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_IF,
      SERVE_DM
   } state_t;

   state_t state;
   state_t next_state;

   logic [SW-1:0] streak;
   logic [31:0]   addr_q;
   logic          write_q;
   logic [31:0]   wdata_q;
   logic [31:0]   if_data_q;
   logic [31:0]   dm_rdata_q;
   logic          grant_if;
   logic          grant_dm;
   logic          if_done;
   logic          dm_done;

   always_comb begin
      next_state = state;
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      unique case (state)
         IDLE: begin
            if (DMReq && (!IFReq || streak < LIMIT)) begin
               grant_dm   = 1'b1;
               next_state = SERVE_DM;
            end else if (IFReq) begin
               grant_if   = 1'b1;
               next_state = SERVE_IF;
            end
         end
         SERVE_IF: if (MemAck) next_state = IDLE;
         SERVE_DM: if (MemAck) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   assign if_done = (state == SERVE_IF) && MemAck;
   assign dm_done = (state == SERVE_DM) && MemAck;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state      <= IDLE;
         streak     <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         if_data_q  <= '0;
         dm_rdata_q <= '0;
      end else begin
         state <= next_state;
         if (grant_dm) begin
            addr_q  <= DMAddr;
            write_q <= DMWrite;
            wdata_q <= DMWData;
            // only DM wins over a waiting IF count toward starvation
            if (!IFReq)
               streak <= '0;
            else if (streak < LIMIT)
               streak <= streak + SW'(1);
         end
         if (grant_if) begin
            addr_q  <= IFAddr;
            write_q <= 1'b0;
            wdata_q <= '0;
            streak  <= '0;
         end
         if (if_done)
            if_data_q <= MemRData;
         if (dm_done && !write_q)
            dm_rdata_q <= MemRData;
      end
   end

   assign Busy     = (state != IDLE);
   assign MemReq   = Busy;
   assign MemWrite = Busy && write_q;
   assign MemAddr  = addr_q;
   assign MemWData = wdata_q;

   assign IFValid  = if_done;
   assign DMValid  = dm_done;
   assign IFData   = if_done ? MemRData : if_data_q;
   assign DMRData  = (dm_done && !write_q) ? MemRData : dm_rdata_q;

   assign IFStall  = IFReq && !IFValid;
   assign DMStall  = DMReq && !DMValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

   localparam int LIM = 3;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        IFReq = 1'b0;
   logic [31:0] IFAddr = '0;
   logic [31:0] IFData;
   logic        IFValid;
   logic        DMReq = 1'b0;
   logic        DMWrite = 1'b0;
   logic [31:0] DMAddr = '0;
   logic [31:0] DMWData = '0;
   logic [31:0] DMRData;
   logic        DMValid;
   logic        MemReq;
   logic        MemWrite;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData = '0;
   logic        MemAck = 1'b0;
   logic        IFStall;
   logic        DMStall;
   logic        Busy;

   mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .Clk(Clk), .Rst(Rst),
      .IFReq(IFReq), .IFAddr(IFAddr),
      .IFData(IFData), .IFValid(IFValid),
      .DMReq(DMReq), .DMWrite(DMWrite),
      .DMAddr(DMAddr), .DMWData(DMWData),
      .DMRData(DMRData), .DMValid(DMValid),
      .MemReq(MemReq), .MemWrite(MemWrite),
      .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .MemAck(MemAck),
      .IFStall(IFStall), .DMStall(DMStall),
      .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who is being served, and what was latched.
   int          m_serving = 0;
   logic [31:0] m_addr = '0;
   logic        m_wr = 1'b0;
   logic [31:0] m_wdata = '0;
   int          m_streak = 0;
   logic [31:0] m_ifdata = '0;
   logic [31:0] m_dmdata = '0;
   int          m_log[$];

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         m_serving <= 0;
         m_addr    <= '0;
         m_wr      <= 1'b0;
         m_wdata   <= '0;
         m_streak  <= 0;
         m_ifdata  <= '0;
         m_dmdata  <= '0;
      end else if (m_serving == 0) begin
         if (DMReq && (!IFReq || m_streak < LIM)) begin
            m_serving <= 2;
            m_addr    <= DMAddr;
            m_wr      <= DMWrite;
            m_wdata   <= DMWData;
            m_streak  <= IFReq ? ((m_streak + 1 > LIM) ?
                         LIM : m_streak + 1) : 0;
            m_log.push_back(2);
         end else if (IFReq) begin
            m_serving <= 1;
            m_addr    <= IFAddr;
            m_wr      <= 1'b0;
            m_streak  <= 0;
            m_log.push_back(1);
         end
      end else if (MemAck) begin
         if (m_serving == 1)
            m_ifdata <= MemRData;
         else if (!m_wr)
            m_dmdata <= MemRData;
         m_serving <= 0;
      end
   end

   always @(negedge Clk) begin
      logic        e_ifv;
      logic        e_dmv;
      logic        e_busy;
      e_busy = (m_serving != 0);
      e_ifv  = (m_serving == 1) && MemAck;
      e_dmv  = (m_serving == 2) && MemAck;
      chk("busy", {31'b0, Busy}, {31'b0, e_busy});
      chk("memreq", {31'b0, MemReq}, {31'b0, e_busy});
      chk("memwrite", {31'b0, MemWrite},
          {31'b0, (m_serving == 2) && m_wr});
      if (e_busy)
         chk("memaddr", MemAddr, m_addr);
      if (m_serving == 2)
         chk("memwdata", MemWData, m_wdata);
      chk("ifvalid", {31'b0, IFValid}, {31'b0, e_ifv});
      chk("dmvalid", {31'b0, DMValid}, {31'b0, e_dmv});
      chk("ifdata", IFData, e_ifv ? MemRData : m_ifdata);
      chk("dmrdata", DMRData,
          (e_dmv && !m_wr) ? MemRData : m_dmdata);
      chk("ifstall", {31'b0, IFStall},
          {31'b0, IFReq && !e_ifv});
      chk("dmstall", {31'b0, DMStall},
          {31'b0, DMReq && !e_dmv});
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   int          log0;
   int          exp_order[5];
   logic [31:0] exp_addr;

   initial begin
      exp_order = '{2, 2, 2, 1, 2};
      // reset state
      cyc();
      cyc();
      #1;
      chk("rst_busy", {31'b0, Busy}, 32'd0);
      chk("rst_memreq", {31'b0, MemReq}, 32'd0);
      chk("rst_ifdata", IFData, 32'd0);
      chk("rst_dmrdata", DMRData, 32'd0);
      cyc();
      Rst = 1'b0;

      // lone fetch, ack two cycles after MemReq
      IFReq = 1'b1;
      IFAddr = 32'h40;
      cyc();
      #1;
      chk("fetch_addr", MemAddr, 32'h40);
      chk("fetch_wr", {31'b0, MemWrite}, 32'd0);
      cyc();
      MemAck = 1'b1;
      MemRData = 32'h8C090004;
      #1;
      chk("fetch_valid", {31'b0, IFValid}, 32'd1);
      chk("fetch_data", IFData, 32'h8C090004);
      cyc();
      MemAck = 1'b0;
      IFReq = 1'b0;
      MemRData = 32'h0;
      #1;
      chk("fetch_idle", {31'b0, Busy}, 32'd0);
      chk("fetch_hold", IFData, 32'h8C090004);
      chk("fetch_vpulse", {31'b0, IFValid}, 32'd0);
      cyc();

      // simultaneous requests, DM store first; address change ignored
      IFReq = 1'b1;
      IFAddr = 32'h44;
      DMReq = 1'b1;
      DMWrite = 1'b1;
      DMAddr = 32'h100;
      DMWData = 32'hDEADBEEF;
      cyc();
      #1;
      chk("sim_dm_addr", MemAddr, 32'h100);
      chk("sim_dm_wr", {31'b0, MemWrite}, 32'd1);
      chk("sim_dm_wdata", MemWData, 32'hDEADBEEF);
      chk("sim_ifstall", {31'b0, IFStall}, 32'd1);
      DMAddr = 32'h200;
      cyc();
      #1;
      chk("stable_addr", MemAddr, 32'h100);
      MemAck = 1'b1;
      MemRData = 32'h55AA55AA;
      #1;
      chk("store_dmv", {31'b0, DMValid}, 32'd1);
      chk("store_rdata", DMRData, 32'd0);
      cyc();
      MemAck = 1'b0;
      DMReq = 1'b0;
      DMWrite = 1'b0;
      cyc();
      #1;
      chk("sim_if_addr", MemAddr, 32'h44);
      chk("sim_if_busy", {31'b0, Busy}, 32'd1);
      MemAck = 1'b1;
      MemRData = 32'h11112222;
      cyc();
      MemAck = 1'b0;
      chk("store_hold", DMRData, 32'd0);
      chk("model_streak0", m_streak, 32'd0);

      // starvation: IF held, DM re-requests after each completion
      IFAddr = 32'h80;
      DMReq = 1'b1;
      DMAddr = 32'h300;
      log0 = m_log.size();
      for (int k = 0; k < 5; k++) begin
         cyc();
         #1;
         exp_addr = (exp_order[k] == 1) ? 32'h80 : 32'h300;
         chk($sformatf("starve_addr%0d", k), MemAddr, exp_addr);
         MemAck = 1'b1;
         MemRData = 32'hA0 + k;
         cyc();
         MemAck = 1'b0;
         if (k == 3)
            chk("starve_streak", m_streak, 32'd0);
      end
      IFReq = 1'b0;
      DMReq = 1'b0;
      chk("starve_nlog", m_log.size() - log0, 32'd5);
      for (int k = 0; k < 5; k++)
         if (log0 + k < m_log.size())
            chk($sformatf("starve_order%0d", k),
                m_log[log0 + k], exp_order[k]);
      chk("starve_dmdata", DMRData, 32'hA4);
      chk("starve_ifdata", IFData, 32'hA3);
      cyc();

      // reset during SERVE_IF, then a late ack
      IFReq = 1'b1;
      IFAddr = 32'h500;
      cyc();
      #1;
      Rst = 1'b1;
      #1;
      chk("rst_mid_memreq", {31'b0, MemReq}, 32'd0);
      chk("rst_mid_busy", {31'b0, Busy}, 32'd0);
      chk("rst_mid_ifdata", IFData, 32'd0);
      chk("rst_mid_ifstall", {31'b0, IFStall}, 32'd1);
      cyc();
      Rst = 1'b0;
      IFReq = 1'b0;
      cyc();
      MemAck = 1'b1;
      MemRData = 32'h77777777;
      #1;
      chk("late_ack_ifv", {31'b0, IFValid}, 32'd0);
      chk("late_ack_busy", {31'b0, Busy}, 32'd0);
      cyc();
      chk("late_ack_ifdata", IFData, 32'd0);
      MemAck = 1'b0;
      cyc();

      // stray ack while idle
      MemAck = 1'b1;
      MemRData = 32'hFFFF0000;
      #1;
      chk("stray_ifv", {31'b0, IFValid}, 32'd0);
      chk("stray_dmv", {31'b0, DMValid}, 32'd0);
      cyc();
      chk("stray_busy", {31'b0, Busy}, 32'd0);
      MemAck = 1'b0;

      // lone load
      DMReq = 1'b1;
      DMAddr = 32'h600;
      cyc();
      cyc();
      MemAck = 1'b1;
      MemRData = 32'h12345678;
      #1;
      chk("load_data", DMRData, 32'h12345678);
      cyc();
      MemAck = 1'b0;
      DMReq = 1'b0;
      MemRData = 32'h0;
      #1;
      chk("load_hold", DMRData, 32'h12345678);
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, giving the number of consecutive DM grants allowed while IF waits.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1: single clock; all state on rising edge.
- Rst, in, 1: reset, asynchronous, active-high.
- IFReq, in, 1: fetch request; held until IFValid.
- IFAddr, in, 32: fetch address.
- IFData, out, 32: fetch read data.
- IFValid, out, 1: fetch completion.
- DMReq, in, 1: data-memory request; held until DMValid.
- DMWrite, in, 1: 1 = store, 0 = load.
- DMAddr, in, 32: data address.
- DMWData, in, 32: store data.
- DMRData, out, 32: load data.
- DMValid, out, 1: data completion.
- MemReq, out, 1: backend request.
- MemWrite, out, 1: backend write strobe.
- MemAddr, out, 32: backend address.
- MemWData, out, 32: backend write data.
- MemRData, in, 32: backend read data.
- MemAck, in, 1: backend completion; latency 1..N cycles.
- IFStall, out, 1: stall to hazard unit for the fetch side.
- DMStall, out, 1: stall to hazard unit for the memory side.
- Busy, out, 1: high when the FSM is not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, SERVE_IF and SERVE_DM.
REQ-004 IDLE arbitration:
- DMReq only -> SERVE_DM.
- IFReq only -> SERVE_IF.
- Both requests and streak < STARVE_LIMIT -> SERVE_DM.
- Both requests and streak == STARVE_LIMIT -> SERVE_IF.
- Neither request -> stay in IDLE.
REQ-005 On the IDLE->SERVE transition, SHALL capture the granted requester's address, write flag and write data into internal registers; on IF grants, MemWrite is captured as 0.
REQ-006 While in SERVE_*, SHALL drive MemReq=1 and MemAddr/MemWrite/MemWData from the captured registers, stable until MemAck; requester input changes SHALL be ignored.
REQ-007 In SERVE_IF with MemAck=1:
- IFValid=1 combinationally in that cycle.
- IFData=MemRData in that cycle, and the value is registered.
- Next state is IDLE.
REQ-008 In SERVE_DM with MemAck=1:
- DMValid=1 combinationally in that cycle.
- For loads only, DMRData=MemRData in that cycle, and the value is registered.
- Next state is IDLE.
REQ-009 Outside their completion cycles, IFData and DMRData SHALL hold their last registered values; a store SHALL NOT change DMRData.
REQ-010 IFValid and DMValid SHALL each be a single-cycle pulse per transaction and SHALL never be high in the same cycle.
REQ-011 SHALL return to IDLE after every completion, giving one idle cycle minimum between backend transactions (MemReq=0 in IDLE).
REQ-012 IFStall=IFReq&~IFValid and DMStall=DMReq&~DMValid, both combinational.
REQ-013 Starvation counter "streak" (width ceil(log2(STARVE_LIMIT+1))):
- Increments on each DM grant made while IFReq=1.
- Clears on every IF grant.
- Clears on a DM grant made while IFReq=0.
- Saturates at STARVE_LIMIT.
REQ-014 MemAck received in IDLE SHALL be ignored, with no Valid pulse and no state change.
REQ-015 Busy=1 in SERVE_IF and SERVE_DM, and 0 in IDLE.

Reset
REQ-016 Rst=1 SHALL immediately, without waiting for a clock edge:
- Force the FSM to IDLE.
- Set MemReq, MemWrite, IFValid, DMValid and Busy to 0.
- Clear streak, IFData, DMRData and the captured registers to 0.
REQ-017 Rst asserted mid-transaction SHALL abandon the transaction with no Valid pulse; a late MemAck after Rst deasserts SHALL be ignored per REQ-014.
REQ-018 With Rst=1, IFStall and DMStall SHALL still follow REQ-012, so the pipeline stays stalled while requests are held.

Verification
REQ-019 Lone fetch: IFReq=1, IFAddr=0x40, MemAck 2 cycles after MemReq with MemRData=0x8C090004 -> MemAddr=0x40, MemWrite=0, one IFValid pulse, IFData=0x8C090004, then IDLE for 1 cycle.
REQ-020 Simultaneous requests: IFReq=DMReq=1, DMWrite=1, DMAddr=0x100, DMWData=0xDEADBEEF -> DM is granted first with MemWrite=1; IFStall stays 1; IF is granted next; DMRData is unchanged.
REQ-021 Starvation: IFReq held at 1 and DMReq re-asserted after every DMValid, STARVE_LIMIT=3 -> grant order DM, DM, DM, IF, then DM; streak returns to 0 after the IF grant.
REQ-022 Input stability: change DMAddr from 0x100 to 0x200 during SERVE_DM before MemAck -> MemAddr stays 0x100 until completion.
REQ-023 Reset mid-operation: Rst pulsed during SERVE_IF before MemAck, then MemAck=1 one cycle after Rst deasserts -> MemReq drops without a clock edge, no IFValid pulse, FSM in IDLE, IFData=0.
REQ-024 Stray ack: MemAck=1 in IDLE with no requests -> no Valid pulse, Busy stays 0.
